ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch unit: the initiator on the instruction-memory read port. It drives word-aligned read requests to the instruction memory, captures the returned instruction words together with their PCs into a small in-order buffer, and presents them to decode with a valid/ready handshake. It handles PC sequencing and branch/jump redirects, including flushing any wrong-path words. It sits between the instruction memory and the decode stage of the core.

## Interface
- WIDTH, 32, data and address width.
- RESET_PC, 32'h0, first fetch address after reset.
- BUF_DEPTH, 2, instruction buffer entries; must be a power of two and ≥2.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset_n  in  1  synchronous, active-low reset.
- o_mem_rq  out  1  memory request; high means a read of word o_pc this cycle.
- o_rnw  out  1  read/not-write; constant 1.
- o_pc  out  WIDTH  byte address of the current request; bits [1:0] are always 0.
- i_data  in  WIDTH  instruction word from memory, valid in the same cycle as o_mem_rq.
- i_redirect  in  1  redirect request from execute.
- i_redirect_pc  in  WIDTH  redirect target; bits [1:0] are ignored (treated as 0).
- o_inst_valid  out  1  buffer head is valid.
- o_inst  out  WIDTH  instruction at the buffer head.
- o_inst_pc  out  WIDTH  PC of the instruction at the buffer head.
- i_inst_ready  in  1  decode accepts the head this cycle.

## Operation
- State:
  - fetch PC register (pc);
  - run flag;
  - circular buffer of BUF_DEPTH {inst, pc} entries, with read pointer, write pointer and count (width log2(BUF_DEPTH)+1).
- Reset (i_reset_n=0 at an edge):
  - pc=RESET_PC, run=0, count=0, pointers=0, entry contents=0.
  - run becomes 1 at the first edge with i_reset_n=1.
- o_mem_rq = run & (count < BUF_DEPTH). It depends on registered state only; there is no combinational path from i_inst_ready or i_redirect.
- o_pc = pc. o_rnw = 1.
- Push happens at an edge when o_mem_rq=1 and i_redirect=0:
  - write {i_data, pc} at the write pointer;
  - pc <= pc + 4, wrapping modulo 2^WIDTH.
- Pop happens at an edge when o_inst_valid=1 and i_inst_ready=1: advance the read pointer.
- Push and pop in the same cycle: count unchanged; both pointers advance. Pointers wrap modulo BUF_DEPTH.
- o_inst_valid = (count != 0). o_inst and o_inst_pc come from the head entry.
- Redirect (i_redirect=1 at an edge) has highest priority:
  - count <= 0 and read pointer <= write pointer;
  - pc <= {i_redirect_pc[WIDTH-1:2], 2'b00};
  - any push or pop in that cycle is discarded.
  - The word fetched in the redirect cycle is dropped.
  - The first fetch from the target occurs in the next cycle.
- Redirect while run=0: pc is still loaded, so the first fetch uses the redirect target.
- Reset has priority over redirect.

## Timing
- Reset values:
  - o_mem_rq=0, o_pc=RESET_PC, o_inst_valid=0, o_inst=0, o_inst_pc=0, o_rnw=1.
- Fetch-to-decode latency:
  - a word requested in cycle N is at the buffer head, o_inst_valid=1, in cycle N+1 if the buffer was empty;
  - otherwise it appears behind the older entries.
- Throughput: one instruction per cycle with i_inst_ready held high (steady-state count = 1).
- Backpressure:
  - with i_inst_ready=0, exactly BUF_DEPTH words are fetched, then o_mem_rq drops;
  - o_mem_rq returns to 1 in the cycle after the first pop.
- Redirect: o_inst_valid=0 in cycle N+1; the target word is at the head in cycle N+2.
- Reset asserted mid-operation: all state is cleared at that edge, with no partial updates.

## Test plan
- Reset release, RESET_PC=0, memory word k = 0x1000+k, ready=1 → o_mem_rq rises 1 cycle after release; o_inst/o_inst_pc stream {0x1000,0}, {0x1001,4}, {0x1002,8}… one per cycle.
- ready=0 for 6 cycles → exactly 2 requests (PC 0,4), o_mem_rq=0 thereafter, head stays {0x1000,0}. Raise ready → o_mem_rq returns the next cycle with PC 8, and order is preserved.
- Redirect to 0x123 with a full buffer → next cycle o_inst_valid=0, o_pc=0x120; following cycle head = {word 0x48, 0x120}. No wrong-path word is ever presented.
- Redirect in the same cycle as a pop and a push → pop and push ignored; count=0 after the edge.
- PC wrap: redirect to 0xFFFFFFFC → fetches at 0xFFFFFFFC then 0x00000000.
- i_reset_n low for one cycle mid-stream → all outputs at their reset values the next cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch unit: issues word-aligned reads to instruction memory,
// buffers {inst, pc} pairs in order and hands them to decode.
module ifetch #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               BUF_DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  output logic             o_mem_rq,
  output logic             o_rnw,
  output logic [WIDTH-1:0] o_pc,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_redirect,
  input  logic [WIDTH-1:0] i_redirect_pc,
  output logic             o_inst_valid,
  output logic [WIDTH-1:0] o_inst,
  output logic [WIDTH-1:0] o_inst_pc,
  input  logic             i_inst_ready
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]    DEPTH_C   = CW'(BUF_DEPTH);
  localparam logic [WIDTH-1:0] ALIGN_RST = {RESET_PC[WIDTH-1:2], 2'b00};

  logic [WIDTH-1:0] pc;
  logic             run;
  logic [WIDTH-1:0] buf_inst [BUF_DEPTH];
  logic [WIDTH-1:0] buf_pc   [BUF_DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;

  logic push;
  logic pop;

  // Handshakes: a transfer happens at a rising edge where valid and ready are
  // both high; valid never depends combinationally on ready. The memory side
  // is a fixed-latency read: i_data belongs to o_pc in the same cycle.
  // A redirect cancels both the push and the pop of its cycle.
  assign o_mem_rq     = run & (count < DEPTH_C);
  assign o_rnw        = 1'b1;
  assign o_pc         = pc;
  assign o_inst_valid = (count != '0);
  assign o_inst       = buf_inst[rd_ptr];
  assign o_inst_pc    = buf_pc[rd_ptr];

  assign push = o_mem_rq & ~i_redirect;
  assign pop  = o_inst_valid & i_inst_ready & ~i_redirect;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      pc     <= ALIGN_RST;
      run    <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_inst[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else begin
      run <= 1'b1;
      if (i_redirect) begin
        // Wrong-path entries are dropped by collapsing the read pointer.
        count  <= '0;
        rd_ptr <= wr_ptr;
        pc     <= {i_redirect_pc[WIDTH-1:2], 2'b00};
      end else begin
        if (push) begin
          buf_inst[wr_ptr] <= i_data;
          buf_pc[wr_ptr]   <= pc;
          wr_ptr           <= wr_ptr + 1'b1;
          pc               <= pc + WIDTH'(4);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: memory word at byte address a is 0x1000 + a/4.
module tb_ifetch;

  logic        clk;
  logic        reset_n;
  logic        mem_rq;
  logic        rnw;
  logic [31:0] pc;
  logic [31:0] mem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int n_vec;
  int n_err;

  ifetch #(.WIDTH(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .o_mem_rq     (mem_rq),
    .o_rnw        (rnw),
    .o_pc         (pc),
    .i_data       (mem_data),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .o_inst_valid (inst_valid),
    .o_inst       (inst),
    .o_inst_pc    (inst_pc),
    .i_inst_ready (inst_ready)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_data = 32'h1000 + (pc >> 2);

  // Reset pulse: one edge with reset_n low; returns at the negedge where
  // reset_n is released.
  task automatic do_reset(input logic rdy);
    reset_n    = 1'b0;
    redirect   = 1'b0;
    inst_ready = rdy;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    inst_ready  = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (mem_rq !== 1'b0) begin n_err++; $display("FAIL rst_mem_rq got %0b exp 0", mem_rq); end
    n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got %h exp 0", pc); end
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b exp 0", inst_valid); end
    n_vec++; if (inst !== 32'h0) begin n_err++; $display("FAIL rst_inst got %h exp 0", inst); end
    n_vec++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL rst_inst_pc got %h exp 0", inst_pc); end
    n_vec++; if (rnw !== 1'b1) begin n_err++; $display("FAIL rst_rnw got %0b exp 1", rnw); end
  endtask

  task automatic test_stream();
    reset_n    = 1'b1;
    inst_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (mem_rq !== 1'b1) begin n_err++; $display("FAIL stream_first_rq got %0b exp 1", mem_rq); end
    n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL stream_first_pc got %h exp 0", pc); end
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL stream_first_valid got %0b exp 0", inst_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d] got %0b exp 1", i, inst_valid); end
      n_vec++; if (inst !== 32'h1000 + i) begin n_err++; $display("FAIL stream_inst[%0d] got %h exp %h", i, inst, 32'h1000 + i); end
      n_vec++; if (inst_pc !== 32'(4 * i)) begin n_err++; $display("FAIL stream_inst_pc[%0d] got %h exp %h", i, inst_pc, 4 * i); end
      n_vec++; if (pc !== 32'(4 * (i + 1))) begin n_err++; $display("FAIL stream_pc[%0d] got %h exp %h", i, pc, 4 * (i + 1)); end
    end
  endtask

  task automatic test_backpressure();
    int n_req;
    logic [31:0] req_pc [2];
    n_req = 0;
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (mem_rq === 1'b1) begin
        if (n_req < 2) req_pc[n_req] = pc;
        n_req++;
      end
    end
    n_vec++; if (n_req !== 2) begin n_err++; $display("FAIL bp_req_count got %0d exp 2", n_req); end
    n_vec++; if (req_pc[0] !== 32'h0) begin n_err++; $display("FAIL bp_req0_pc got %h exp 0", req_pc[0]); end
    n_vec++; if (req_pc[1] !== 32'h4) begin n_err++; $display("FAIL bp_req1_pc got %h exp 4", req_pc[1]); end
    n_vec++; if (mem_rq !== 1'b0) begin n_err++; $display("FAIL bp_rq_low got %0b exp 0", mem_rq); end
    n_vec++; if (inst !== 32'h1000 || inst_pc !== 32'h0) begin n_err++; $display("FAIL bp_head got {%h,%h} exp {1000,0}", inst, inst_pc); end
    inst_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (mem_rq !== 1'b1 || pc !== 32'h8) begin n_err++; $display("FAIL bp_resume got rq=%0b pc=%h exp rq=1 pc=8", mem_rq, pc); end
    n_vec++; if (inst !== 32'h1001 || inst_pc !== 32'h4) begin n_err++; $display("FAIL bp_head1 got {%h,%h} exp {1001,4}", inst, inst_pc); end
    @(negedge clk);
    n_vec++; if (inst !== 32'h1002 || inst_pc !== 32'h8) begin n_err++; $display("FAIL bp_head2 got {%h,%h} exp {1002,8}", inst, inst_pc); end
    @(negedge clk);
    n_vec++; if (inst !== 32'h1003 || inst_pc !== 32'hc) begin n_err++; $display("FAIL bp_head3 got {%h,%h} exp {1003,c}", inst, inst_pc); end
  endtask

  task automatic test_redirect_full();
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    n_vec++; if (mem_rq !== 1'b0 || inst_valid !== 1'b1) begin n_err++; $display("FAIL rdf_full got rq=%0b valid=%0b exp rq=0 valid=1", mem_rq, inst_valid); end
    redirect    = 1'b1;
    redirect_pc = 32'h123;
    @(negedge clk);
    redirect = 1'b0;
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rdf_valid got %0b exp 0", inst_valid); end
    n_vec++; if (pc !== 32'h120 || mem_rq !== 1'b1) begin n_err++; $display("FAIL rdf_pc got pc=%h rq=%0b exp pc=120 rq=1", pc, mem_rq); end
    inst_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL rdf_target_valid got %0b exp 1", inst_valid); end
    n_vec++; if (inst !== 32'h1048 || inst_pc !== 32'h120) begin n_err++; $display("FAIL rdf_target got {%h,%h} exp {1048,120}", inst, inst_pc); end
    n_vec++; if (pc !== 32'h124) begin n_err++; $display("FAIL rdf_next_pc got %h exp 124", pc); end
  endtask

  task automatic test_redirect_pop_push();
    do_reset(1'b1);
    repeat (2) @(negedge clk);
    n_vec++; if (inst_valid !== 1'b1 || mem_rq !== 1'b1) begin n_err++; $display("FAIL rpp_setup got valid=%0b rq=%0b exp 1/1", inst_valid, mem_rq); end
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rpp_count0 got valid=%0b exp 0", inst_valid); end
    n_vec++; if (pc !== 32'h200) begin n_err++; $display("FAIL rpp_pc got %h exp 200", pc); end
    @(negedge clk);
    n_vec++; if (inst !== 32'h1080 || inst_pc !== 32'h200) begin n_err++; $display("FAIL rpp_target got {%h,%h} exp {1080,200}", inst, inst_pc); end
    @(negedge clk);
    n_vec++; if (inst !== 32'h1081 || inst_pc !== 32'h204) begin n_err++; $display("FAIL rpp_next got {%h,%h} exp {1081,204}", inst, inst_pc); end
  endtask

  // Redirect lands on the edge where run is still 0, and the target wraps.
  task automatic test_pc_wrap();
    reset_n    = 1'b0;
    redirect   = 1'b0;
    inst_ready = 1'b1;
    @(negedge clk);
    reset_n     = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hffff_fffe;
    @(negedge clk);
    redirect = 1'b0;
    n_vec++; if (mem_rq !== 1'b1 || pc !== 32'hffff_fffc) begin n_err++; $display("FAIL wrap_first got rq=%0b pc=%h exp rq=1 pc=fffffffc", mem_rq, pc); end
    @(negedge clk);
    n_vec++; if (inst !== 32'h4000_0fff || inst_pc !== 32'hffff_fffc) begin n_err++; $display("FAIL wrap_head0 got {%h,%h} exp {40000fff,fffffffc}", inst, inst_pc); end
    n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc got %h exp 0", pc); end
    @(negedge clk);
    n_vec++; if (inst !== 32'h1000 || inst_pc !== 32'h0) begin n_err++; $display("FAIL wrap_head1 got {%h,%h} exp {1000,0}", inst, inst_pc); end
  endtask

  // Reset mid-stream, with a simultaneous redirect that reset must override.
  task automatic test_reset_mid();
    do_reset(1'b1);
    repeat (4) @(negedge clk);
    reset_n     = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    @(negedge clk);
    reset_n  = 1'b1;
    redirect = 1'b0;
    n_vec++; if (mem_rq !== 1'b0 || pc !== 32'h0) begin n_err++; $display("FAIL mid_rst_fetch got rq=%0b pc=%h exp rq=0 pc=0", mem_rq, pc); end
    n_vec++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin n_err++; $display("FAIL mid_rst_head got v=%0b {%h,%h} exp v=0 {0,0}", inst_valid, inst, inst_pc); end
    @(negedge clk);
    n_vec++; if (mem_rq !== 1'b1 || pc !== 32'h0) begin n_err++; $display("FAIL mid_restart got rq=%0b pc=%h exp rq=1 pc=0", mem_rq, pc); end
    @(negedge clk);
    n_vec++; if (inst !== 32'h1000 || inst_pc !== 32'h0) begin n_err++; $display("FAIL mid_head got {%h,%h} exp {1000,0}", inst, inst_pc); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_redirect_pop_push();
    test_pc_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
